shift_ex_unit: RTL and testbench
================================

Name: shift_ex_unit

Overview:
EX-stage consumer of the shift control bits registered by the ID/EX pipeline registers (sll/srl/sra control, rt data, shamt, rd address). It is an iterative multi-cycle shifter. It latches one shift instruction, shifts it STEP bits per cycle, and presents a registered result toward EX/MEM. While busy it raises a stall so the hazard logic freezes ID/EX and earlier stages.

Parameters:
DATA_W, 32, operand/result width
SHAMT_W, 5, shift-amount width (must equal clog2(DATA_W))
STEP, 1, max bits shifted per cycle; power of two, 1..DATA_W; checked at elaboration

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous kill of the in-flight op (branch/exception)
in_valid  input  1  ID/EX holds a valid instruction
op_sll  input  1  registered sll control from ID/EX
op_srl  input  1  registered srl control from ID/EX
op_sra  input  1  registered sra control from ID/EX
rt_data  input  DATA_W  operand to shift
shamt  input  SHAMT_W  shift amount
rd_addr  input  5  destination register
stall  output  1  unit busy; freeze ID/EX and upstream
result_valid  output  1  result/result_rd valid this cycle
result  output  DATA_W  shifted value
result_rd  output  5  destination of result
err_op  output  1  one-cycle pulse: in_valid with op bits not one-hot (and not all zero)

Behaviour:
- Reset is the only asynchronous path. reset_n low forces the following immediately: state=IDLE, stall=0, result_valid=0, result=0, result_rd=0, err_op=0, internal count/operand=0. This holds mid-operation too; the in-flight op is lost.
- States: IDLE, SHIFT, DONE. stall = (state != IDLE), decoded from registered state only.
- Accept: in IDLE, when in_valid=1, exactly one op bit is set and flush=0, latch rt_data, shamt, rd_addr and op.
  - shamt==0: next state is DONE.
  - Otherwise: next state is SHIFT with count=shamt.
- In IDLE, if all op bits are 0, the instruction is not a shift: no action.
- In IDLE, if in_valid=1 and more than one op bit is set: no accept, and err_op=1 for the next cycle only.
- SHIFT, each edge:
  - amt = min(count, STEP).
  - Operand is shifted by amt: sll fills with zeros; srl fills with zeros; sra fills with operand[DATA_W-1].
  - count -= amt.
  - If the new count is 0, go to DONE.
- DONE: result_valid=1 for exactly one cycle with result and result_rd. Next state is IDLE unconditionally; no accept occurs in DONE.
- result and result_rd are registered. They hold their last value after result_valid drops.
- Latency: with acceptance at edge E0, result_valid is high in the cycle after edge E0+ceil(shamt/STEP). stall is high for ceil(shamt/STEP)+1 cycles.
- in_valid is ignored while stall=1; ID/EX is frozen upstream.
- flush (synchronous, highest priority after reset):
  - Next state is IDLE; no result_valid is produced for the killed op.
  - flush in DONE suppresses that cycle's successor but not the current pulse, which is already registered.
  - flush in IDLE blocks acceptance.
- Arithmetic: all shifts are DATA_W wide; bits shifted out are discarded. shamt = DATA_W-1 is the maximum.

Decomposition:
- Package shift_ex_pkg holds:
  - State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Op encoding: OP_SLL=2'd0, OP_SRL=2'd1, OP_SRA=2'd2.
  - Default widths.
- One combinational sub-module, shift_step: (operand, amt, op) -> shifted operand, with amt range 0..STEP. It is reused for any future multi-step shifter.

Test Plan:
- sll rt=0x0000_0001, shamt=4, STEP=1, rd=5 -> stall high 5 cycles; result_valid for 1 cycle with result=0x0000_0010, result_rd=5.
- sra rt=0x8000_0000, shamt=31, STEP=4 -> 8 SHIFT cycles, then result=0xFFFF_FFFF; stall high 9 cycles.
- srl rt=0x8000_0000, shamt=0 -> no SHIFT; result_valid in cycle after accept with result=0x8000_0000; stall high 1 cycle.
- sll shamt=10, STEP=1, flush on 3rd SHIFT cycle -> no result_valid; stall low next cycle; a following srl 0xF0 shamt=4 accepted and returns 0x0F.
- in_valid with op_sll=op_srl=1 -> err_op pulse 1 cycle; stall stays 0; no result_valid.
- reset_n low mid-SHIFT -> all outputs 0 without waiting for a clock edge; after release, sll 0x3 shamt=1 -> result 0x6.

Source files
------------

// File: rtl/shift_ex_pkg.sv
// ---------------------------------------------------------------------------
// shift_ex_pkg : shared types and defaults for the EX-stage iterative shifter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shift_ex_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 5;
  localparam int STEP_DEF    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2
  } op_t;

  // Only meaningful for a one-hot op vector.
  function automatic op_t encode_op(input logic sll, input logic srl);
    if (sll)      return OP_SLL;
    else if (srl) return OP_SRL;
    else          return OP_SRA;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_ex_unit_if.sv
// ---------------------------------------------------------------------------
// shift_ex_unit_if : ID/EX request bundle and EX/MEM result bundle
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface shift_ex_unit_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);

  logic               flush;
  logic               in_valid;
  logic               op_sll;
  logic               op_srl;
  logic               op_sra;
  logic [DATA_W-1:0]  rt_data;
  logic [SHAMT_W-1:0] shamt;
  logic [4:0]         rd_addr;

  logic               stall;
  logic               result_valid;
  logic [DATA_W-1:0]  result;
  logic [4:0]         result_rd;
  logic               err_op;

  modport master (
    output flush, in_valid, op_sll, op_srl, op_sra, rt_data, shamt, rd_addr,
    input  stall, result_valid, result, result_rd, err_op
  );

  modport slave (
    input  flush, in_valid, op_sll, op_srl, op_sra, rt_data, shamt, rd_addr,
    output stall, result_valid, result, result_rd, err_op
  );

endinterface

`default_nettype wire

// File: rtl/shift_ex_unit_shift_step.sv
// ---------------------------------------------------------------------------
// shift_step : one bounded shift step (0..STEP bits) for sll/srl/sra
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_step
  import shift_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 1,
  parameter int AMT_W  = $clog2(STEP + 1)
) (
  input  logic [DATA_W-1:0] operand,
  input  logic [AMT_W-1:0]  amt,
  input  op_t               op,
  output logic [DATA_W-1:0] shifted
);

  always_comb begin
    shifted = operand;
    case (op)
      OP_SLL:  shifted = operand << amt;
      OP_SRL:  shifted = operand >> amt;
      OP_SRA:  shifted = DATA_W'($signed(operand) >>> amt);
      default: shifted = operand;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_ex_unit.sv
// ---------------------------------------------------------------------------
// shift_ex_unit : iterative EX-stage shifter, STEP bits per cycle, with stall
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_ex_unit
  import shift_ex_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int STEP    = STEP_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  shift_ex_unit_if.slave  bus
);

  localparam int AMT_W = $clog2(STEP + 1);

  generate
    if ((STEP < 1) || (STEP > DATA_W) || ((STEP & (STEP - 1)) != 0)) begin : g_bad_step
      $error("shift_ex_unit: STEP must be a power of two in 1..DATA_W");
    end
    if (SHAMT_W != $clog2(DATA_W)) begin : g_bad_shamt_w
      $error("shift_ex_unit: SHAMT_W must equal clog2(DATA_W)");
    end
  endgenerate

  state_t             state;
  op_t                op;
  logic [SHAMT_W-1:0] count;
  logic [DATA_W-1:0]  operand;
  logic [4:0]         rd;
  logic               result_valid;
  logic [DATA_W-1:0]  result;
  logic [4:0]         result_rd;
  logic               err_op;

  logic               any_op;
  logic               one_hot;
  logic [AMT_W-1:0]   amt;
  logic [SHAMT_W-1:0] count_next;
  logic [DATA_W-1:0]  shifted;

  assign any_op  = bus.op_sll | bus.op_srl | bus.op_sra;
  assign one_hot = (bus.op_sll ^ bus.op_srl ^ bus.op_sra) &
                   ~(bus.op_sll & bus.op_srl & bus.op_sra);

  // Final step may be shorter than STEP when the remaining count runs out.
  always_comb begin
    amt = AMT_W'(STEP);
    if (int'(count) < STEP) amt = AMT_W'(count);
    count_next = count - SHAMT_W'(amt);
  end

  shift_step #(
    .DATA_W (DATA_W),
    .STEP   (STEP),
    .AMT_W  (AMT_W)
  ) u_shift_step (
    .operand (operand),
    .amt     (amt),
    .op      (op),
    .shifted (shifted)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      op           <= OP_SLL;
      count        <= '0;
      operand      <= '0;
      rd           <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      result_rd    <= '0;
      err_op       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      err_op       <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.in_valid && one_hot) begin
              op      <= encode_op(bus.op_sll, bus.op_srl);
              operand <= bus.rt_data;
              rd      <= bus.rd_addr;
              count   <= bus.shamt;
              if (bus.shamt == '0) begin
                // Result is registered on entry to DONE so it is visible there.
                state        <= DONE;
                result_valid <= 1'b1;
                result       <= bus.rt_data;
                result_rd    <= bus.rd_addr;
              end else begin
                state <= SHIFT;
              end
            end else if (bus.in_valid && any_op) begin
              err_op <= 1'b1;
            end
          end
          SHIFT: begin
            operand <= shifted;
            count   <= count_next;
            if (count_next == '0) begin
              state        <= DONE;
              result_valid <= 1'b1;
              result       <= shifted;
              result_rd    <= rd;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.stall        = (state != IDLE);
  assign bus.result_valid = result_valid;
  assign bus.result       = result;
  assign bus.result_rd    = result_rd;
  assign bus.err_op       = err_op;

endmodule

`default_nettype wire

// File: tb/tb_shift_ex_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_ex_unit : directed + random checks of two shifter instances (STEP 1 and 4)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_ex_unit;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [2:0]  ops;
  logic [31:0] rt_data;
  logic [4:0]  shamt;
  logic [4:0]  rd_addr;

  int total;
  int passed;

  shift_ex_unit_if #(.DATA_W(32), .SHAMT_W(5)) bus1 ();
  shift_ex_unit_if #(.DATA_W(32), .SHAMT_W(5)) bus4 ();

  assign bus1.flush    = flush;
  assign bus1.in_valid = in_valid;
  assign bus1.op_sll   = ops[2];
  assign bus1.op_srl   = ops[1];
  assign bus1.op_sra   = ops[0];
  assign bus1.rt_data  = rt_data;
  assign bus1.shamt    = shamt;
  assign bus1.rd_addr  = rd_addr;
  assign bus4.flush    = flush;
  assign bus4.in_valid = in_valid;
  assign bus4.op_sll   = ops[2];
  assign bus4.op_srl   = ops[1];
  assign bus4.op_sra   = ops[0];
  assign bus4.rt_data  = rt_data;
  assign bus4.shamt    = shamt;
  assign bus4.rd_addr  = rd_addr;

  shift_ex_unit #(.DATA_W(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  shift_ex_unit #(.DATA_W(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus4.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: plain shift operators applied in one go to the full operand.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] v,
                                        input logic [4:0] s);
    if (o == 3'b100)      return v << s;
    else if (o == 3'b010) return v >> s;
    else                  return $signed(v) >>> s;
  endfunction

  task automatic check_unit(input string nm, input int j, input int n, input int fl,
                            input logic st, input logic rv, input logic [31:0] res,
                            input logic [4:0] rrd, input logic [31:0] exp_res,
                            input logic [4:0] exp_rd);
    logic exp_st;
    logic exp_rv;
    exp_st = (j <= n + 1) && (j <= fl);
    exp_rv = (j == n + 1) && (j <= fl);
    chk({nm, "_stall"}, 32'(st), 32'(exp_st));
    chk({nm, "_result_valid"}, 32'(rv), 32'(exp_rv));
    if (exp_rv || (j > n + 1 && fl > n + 1)) begin
      chk({nm, "_result"}, res, exp_res);
      chk({nm, "_result_rd"}, 32'(rrd), 32'(exp_rd));
    end
  endtask

  // Called at a negedge with both units idle; returns at a negedge with both idle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] v, input logic [4:0] s,
                        input logic [4:0] rd, input int flush_at);
    logic [31:0] exp_res;
    int n1;
    int n4;
    int fl;
    exp_res = model(o, v, s);
    n1 = int'(s);
    n4 = (int'(s) + 3) / 4;
    fl = (flush_at == 0) ? 1000 : flush_at;
    chk("pre_stall1", 32'(bus1.stall), 32'd0);
    in_valid = 1'b1;
    ops      = o;
    rt_data  = v;
    shamt    = s;
    rd_addr  = rd;
    @(negedge clock);
    in_valid = 1'b0;
    ops      = $urandom_range(7, 0);
    rt_data  = $urandom;
    shamt    = 5'($urandom);
    rd_addr  = 5'($urandom);
    for (int j = 1; j <= n1 + 2; j++) begin
      check_unit("s1", j, n1, fl, bus1.stall, bus1.result_valid, bus1.result,
                 bus1.result_rd, exp_res, rd);
      check_unit("s4", j, n4, fl, bus4.stall, bus4.result_valid, bus4.result,
                 bus4.result_rd, exp_res, rd);
      flush = (j == flush_at);
      @(negedge clock);
    end
    flush = 1'b0;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [4:0]  rs;
    int          rf;
    total    = 0;
    passed   = 0;
    reset_n  = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    ops      = 3'b000;
    rt_data  = '0;
    shamt    = '0;
    rd_addr  = '0;

    @(negedge clock);
    chk("rst_stall", 32'(bus1.stall), 32'd0);
    chk("rst_rv", 32'(bus1.result_valid), 32'd0);
    chk("rst_result", bus4.result, 32'd0);
    chk("rst_err", 32'(bus4.err_op), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_op(3'b100, 32'h0000_0001, 5'd4, 5'd5, 0);
    run_op(3'b001, 32'h8000_0000, 5'd31, 5'd9, 0);
    run_op(3'b010, 32'h8000_0000, 5'd0, 5'd12, 0);
    run_op(3'b100, 32'h1234_5678, 5'd10, 5'd3, 3);
    run_op(3'b010, 32'h0000_00F0, 5'd4, 5'd7, 0);
    run_op(3'b001, 32'h8765_4321, 5'd5, 5'd20, 6);

    // Non-one-hot op: error pulse only, never accepted.
    in_valid = 1'b1;
    ops      = 3'b110;
    @(negedge clock);
    in_valid = 1'b0;
    chk("err1_pulse", 32'(bus1.err_op), 32'd1);
    chk("err4_pulse", 32'(bus4.err_op), 32'd1);
    chk("err_stall", 32'(bus1.stall | bus4.stall), 32'd0);
    chk("err_rv", 32'(bus1.result_valid | bus4.result_valid), 32'd0);
    @(negedge clock);
    chk("err1_drop", 32'(bus1.err_op), 32'd0);
    chk("err4_drop", 32'(bus4.err_op), 32'd0);

    // All-zero op vector is not a shift.
    in_valid = 1'b1;
    ops      = 3'b000;
    @(negedge clock);
    in_valid = 1'b0;
    chk("noop_err", 32'(bus1.err_op | bus4.err_op), 32'd0);
    chk("noop_stall", 32'(bus1.stall | bus4.stall), 32'd0);

    // Asynchronous reset in the middle of a shift.
    in_valid = 1'b1;
    ops      = 3'b100;
    rt_data  = 32'h0000_FFFF;
    shamt    = 5'd20;
    rd_addr  = 5'd17;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    chk("pre_rst_stall", 32'(bus1.stall), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_stall1", 32'(bus1.stall), 32'd0);
    chk("arst_stall4", 32'(bus4.stall), 32'd0);
    chk("arst_result1", bus1.result, 32'd0);
    chk("arst_result4", bus4.result, 32'd0);
    chk("arst_rd", 32'(bus1.result_rd | bus4.result_rd), 32'd0);
    chk("arst_rv_err", 32'(bus1.result_valid | bus1.err_op), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_op(3'b100, 32'h0000_0003, 5'd1, 5'd2, 0);

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(2, 0))
        0:       ro = 3'b100;
        1:       ro = 3'b010;
        default: ro = 3'b001;
      endcase
      rs = 5'($urandom);
      rf = ($urandom_range(3, 0) == 0) ? $urandom_range(int'(rs) + 1, 1) : 0;
      run_op(ro, $urandom, rs, 5'($urandom), rf);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
